a2d_intf: RTL and testbench



---
 rtl/a2d_pkg.sv | 23 ++
 rtl/spi_shift16.sv | 43 ++++
 rtl/a2d_intf.sv | 120 ++++++++++++
 tb/tb_a2d_intf.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared state type and timing constants for the ADC SPI interface
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRAME1 = 3'd1,
    GAP    = 3'd2,
    FRAME2 = 3'd3,
    DONE   = 3'd4
  } a2d_state_e;

  localparam int                    SCLK_DIV_W = 5;
  localparam logic [4:0]            FRAME_BITS = 5'd16;
  localparam logic [SCLK_DIV_W-1:0] PORCH_LOAD = 5'b10111;
  localparam logic [SCLK_DIV_W-1:0] SHIFT_AT   = 5'b11111;
  localparam logic [SCLK_DIV_W-1:0] SAMPLE_AT  = 5'b01111;
  localparam logic [SCLK_DIV_W-1:0] END_AT     = 5'b11110;

  function automatic logic [15:0] cmd_word(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/spi_shift16.sv
// rtl/spi_shift16.sv - 16-bit parallel-load transmit / serial-in receive shift register
module spi_shift16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] load_data_i,
  input  logic        shift_i,
  input  logic        sample_i,
  input  logic        miso_i,
  output logic        mosi_o,
  output logic [15:0] rx_data_o
);

  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;

  // A load starts a new frame, so the receive side is cleared at the same time.
  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load_i) begin
      tx_d = load_data_i;
      rx_d = 16'h0000;
    end else begin
      if (shift_i)  tx_d = {tx_q[14:0], 1'b0};
      if (sample_i) rx_d = {rx_q[14:0], miso_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= 16'h0000;
      rx_q <= 16'h0000;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

  assign mosi_o    = tx_q[15];
  assign rx_data_o = rx_q;

endmodule

// File: rtl/a2d_intf.sv
// rtl/a2d_intf.sv - two-frame SPI conversion sequencer for an 8-channel ADC
module a2d_intf
  import a2d_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] res,
  output logic        cnv_cmplt
);

  a2d_state_e            state_q, state_d;
  logic [SCLK_DIV_W-1:0] sclk_div_q, sclk_div_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [2:0]            chnnl_q, chnnl_d;
  logic                  ss_n_q, ss_n_d;
  logic [11:0]           res_q, res_d;
  logic                  cmplt_q, cmplt_d;

  logic        in_frame, frame_end, sample_en, shift_en, load_en;
  logic        mosi_bit;
  logic [15:0] rx_data;
  logic        unused_rx_hi;

  assign in_frame  = (state_q == FRAME1) || (state_q == FRAME2);
  assign frame_end = in_frame && (bit_cnt_q == FRAME_BITS) && (sclk_div_q == END_AT);
  assign sample_en = in_frame && (sclk_div_q == SAMPLE_AT);
  // The first bit is already on MOSI when SS_n falls, so the first shift slot is skipped.
  assign shift_en  = in_frame && (sclk_div_q == SHIFT_AT) && (bit_cnt_q != 5'd0);
  assign load_en   = ((state_q == IDLE) && strt_cnv) || ((state_q == FRAME1) && frame_end);

  spi_shift16 u_shift (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load_en),
    .load_data_i (cmd_word((state_q == IDLE) ? chnnl : chnnl_q)),
    .shift_i     (shift_en),
    .sample_i    (sample_en),
    .miso_i      (MISO),
    .mosi_o      (mosi_bit),
    .rx_data_o   (rx_data)
  );

  assign unused_rx_hi = ^rx_data[15:12];

  // GAP doubles as FRAME2's first porch cycle, which keeps SS_n high for exactly one cycle.
  always_comb begin
    state_d    = state_q;
    sclk_div_d = sclk_div_q + 5'd1;
    bit_cnt_d  = bit_cnt_q + {4'd0, sample_en};
    chnnl_d    = chnnl_q;
    res_d      = res_q;
    cmplt_d    = cmplt_q;
    case (state_q)
      IDLE: begin
        sclk_div_d = sclk_div_q;
        if (strt_cnv) begin
          state_d    = FRAME1;
          chnnl_d    = chnnl;
          cmplt_d    = 1'b0;
          sclk_div_d = PORCH_LOAD;
          bit_cnt_d  = 5'd0;
        end
      end
      FRAME1: begin
        if (frame_end) begin
          state_d    = GAP;
          sclk_div_d = PORCH_LOAD;
          bit_cnt_d  = 5'd0;
        end
      end
      GAP: state_d = FRAME2;
      FRAME2: begin
        if (frame_end) begin
          state_d = DONE;
          res_d   = rx_data[11:0];
          cmplt_d = 1'b1;
        end
      end
      DONE: begin
        state_d    = IDLE;
        sclk_div_d = sclk_div_q;
      end
      default: state_d = IDLE;
    endcase
    ss_n_d = !(((state_q == FRAME1) && (state_d == FRAME1)) || (state_d == FRAME2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sclk_div_q <= '0;
      bit_cnt_q  <= 5'd0;
      chnnl_q    <= 3'd0;
      ss_n_q     <= 1'b1;
      res_q      <= 12'h000;
      cmplt_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_div_q <= sclk_div_d;
      bit_cnt_q  <= bit_cnt_d;
      chnnl_q    <= chnnl_d;
      ss_n_q     <= ss_n_d;
      res_q      <= res_d;
      cmplt_q    <= cmplt_d;
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = in_frame ? sclk_div_q[4] : 1'b1;
  assign MOSI      = !ss_n_q && mosi_bit;
  assign res       = res_q;
  assign cnv_cmplt = cmplt_q;

endmodule

// File: tb/tb_a2d_intf.sv
// tb/tb_a2d_intf.sv - self-checking bench for a2d_intf with a behavioural ADC model
module tb_a2d_intf;

  logic        clk = 1'b0;
  logic        rst;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        MISO = 1'b0;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic [11:0] res;
  logic        cnv_cmplt;

  int checks = 0;
  int failures = 0;

  a2d_intf dut (
    .clk       (clk),
    .rst       (rst),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .MISO      (MISO),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .res       (res),
    .cnv_cmplt (cnv_cmplt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          low;
    int          falls;
    int          porch;
    int          half;
    logic [15:0] mosi;
  } frame_t;

  frame_t      frames[$];
  logic [11:0] adc_val [8];
  logic [11:0] exp_res;

  // ADC model: each frame returns the value of the channel addressed in the previous frame
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b1;
  bit          act = 0;
  bit          fell;
  int          low_n, falls_n, porch_n, lowrun, half_n, bit_i;
  logic [15:0] mosi_w, miso_w;
  logic [2:0]  last_addr = 3'd0;

  always @(negedge clk) begin
    if (rst) begin
      act  = 0;
      MISO = 1'b0;
    end else begin
      if (!SS_n && prev_ss) begin
        act = 1; fell = 0;
        low_n = 0; falls_n = 0; porch_n = 0; lowrun = 0; half_n = 0;
        mosi_w = 16'h0;
        miso_w = {4'($urandom), adc_val[last_addr]};
        bit_i = 15;
      end
      if (act && !SS_n) begin
        low_n++;
        if (SCLK && !fell) porch_n++;
        if (prev_sclk && !SCLK) begin
          falls_n++;
          fell = 1;
          lowrun = 0;
          if (bit_i >= 0) MISO = miso_w[bit_i];
          bit_i--;
        end
        if (!SCLK) lowrun++;
        if (SCLK && !prev_sclk) begin
          mosi_w = {mosi_w[14:0], MOSI};
          half_n = lowrun;
        end
      end
      if (act && SS_n && !prev_ss) begin
        frames.push_back('{low: low_n, falls: falls_n, porch: porch_n, half: half_n, mosi: mosi_w});
        last_addr = mosi_w[13:11];
        act = 0;
      end
    end
    prev_ss   = SS_n;
    prev_sclk = SCLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input logic [2:0] ch, input int ign_at, input logic [2:0] ign_ch,
                          input int rst_at);
    int          n;
    bit          aborted;
    logic [11:0] prev_res;
    frame_t      f;
    prev_res = exp_res;
    n        = 0;
    aborted  = 0;
    strt_cnv = 1'b1;
    chnnl    = ch;
    while (!aborted && n < 1100 && (n == 0 || cnv_cmplt !== 1'b1)) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        strt_cnv = 1'b0;
        chnnl    = 3'($urandom);
        chk("cmplt_clear", cnv_cmplt, 0);
        chk("ss_n_setup", SS_n, 1);
        chk("res_hold", res, prev_res);
      end
      if (n == ign_at) begin
        strt_cnv = 1'b1;
        chnnl    = ign_ch;
      end
      if (n == ign_at + 1) strt_cnv = 1'b0;
      if (n == rst_at) rst = 1'b1;
      if (n == rst_at + 1) begin
        chk("rst_ss_n", SS_n, 1);
        chk("rst_sclk", SCLK, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_res", res, 0);
        chk("rst_cmplt", cnv_cmplt, 0);
        rst     = 1'b0;
        aborted = 1;
      end
    end
    if (aborted) begin
      exp_res = 12'h000;
      repeat (20) @(negedge clk);
      chk("abort_idle_ss_n", SS_n, 1);
      chk("abort_no_cmplt", cnv_cmplt, 0);
      frames.delete();
    end else begin
      exp_res = adc_val[ch];
      chk("latency", n - 1, 1040);
      chk("res", res, exp_res);
      chk("cmplt_set", cnv_cmplt, 1);
      // start request during the DONE cycle must be dropped
      strt_cnv = 1'b1;
      chnnl    = 3'($urandom);
      @(negedge clk);
      strt_cnv = 1'b0;
      chk("nframes", frames.size(), 2);
      while (frames.size() > 0) begin
        f = frames.pop_front();
        chk("ss_low_cycles", f.low, 519);
        chk("sclk_falls", f.falls, 16);
        chk("front_porch", f.porch, 8);
        chk("sclk_half", f.half, 16);
        chk("mosi_word", f.mosi, {2'b00, ch, 11'h000});
      end
      repeat (3) @(negedge clk);
      chk("done_strt_ss_n", SS_n, 1);
      chk("cmplt_level", cnv_cmplt, 1);
      chk("res_level", res, exp_res);
    end
  endtask

  initial begin
    logic [2:0] rch;
    rst      = 1'b1;
    strt_cnv = 1'b0;
    chnnl    = 3'd0;
    exp_res  = 12'h000;
    foreach (adc_val[i]) adc_val[i] = 12'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_ss_n", SS_n, 1);
    chk("reset_sclk", SCLK, 1);
    chk("reset_mosi", MOSI, 0);
    chk("reset_res", res, 0);
    chk("reset_cmplt", cnv_cmplt, 0);
    rst = 1'b0;
    @(negedge clk);

    adc_val[5] = 12'hA5C;
    run_conv(3'd5, -10, 3'd0, -10);

    adc_val[2] = 12'h3C1;
    run_conv(3'd5, 300, 3'd2, -10);

    run_conv(3'd5, -10, 3'd0, 700);
    adc_val[3] = 12'h6B9;
    run_conv(3'd3, -10, 3'd0, -10);

    adc_val[0] = 12'h000;
    adc_val[7] = 12'hFFF;
    run_conv(3'd0, -10, 3'd0, -10);
    run_conv(3'd7, -10, 3'd0, -10);

    repeat (3) begin
      rch          = 3'($urandom);
      adc_val[rch] = 12'($urandom);
      run_conv(rch, -10, 3'd0, -10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
